// File: rtl/traffic_sched_pkg.sv
// Shared types and helpers for the traffic phase scheduler.
package traffic_sched_pkg;

    localparam int unsigned PH_NUM = 4;

    typedef enum logic [1:0] {
        PH_NS_STR  = 2'd0,
        PH_NS_LEFT = 2'd1,
        PH_EW_STR  = 2'd2,
        PH_EW_LEFT = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        SERVICE,
        FAULT
    } sched_state_e;

    // Pedestrian axis owning a phase: 0 = NS, 1 = EW.
    function automatic logic axis_of(input phase_e ph);
        return (ph == PH_EW_STR) || (ph == PH_EW_LEFT);
    endfunction

endpackage

// File: rtl/phase_rr_picker.sv
// Rotating find-first: returns the first set mask bit at or after the pointer, modulo 4.
module phase_rr_picker
    import traffic_sched_pkg::*;
(
    input  logic [PH_NUM-1:0] i_mask,
    input  logic [1:0]        i_ptr,
    output logic [1:0]        o_idx,
    output logic              o_found
);

    logic [1:0] w_cand;

    // Scan the farthest offset first so the nearest hit overwrites it last.
    always_comb begin
        o_idx   = i_ptr;
        o_found = 1'b0;
        w_cand  = i_ptr;
        for (int k = PH_NUM - 1; k >= 0; k--) begin
            w_cand = i_ptr + 2'(k);
            if (i_mask[w_cand]) begin
                o_idx   = w_cand;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Latches phase/ped/emergency calls and offers one phase at a time to the intersection FSM,
// choosing emergency first, then starved, then round-robin.
module traffic_phase_scheduler
    import traffic_sched_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_WAIT    = 60,
    parameter logic [3:0]  RECALL_MASK = 4'b0101
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick_1hz,
    input  logic [3:0] i_call_in,
    input  logic [1:0] i_ped_call,
    input  logic       i_emergency_req,
    input  logic [1:0] i_emergency_phase,
    input  logic       i_system_fault,
    output logic       o_grant_valid,
    output logic [1:0] o_grant_phase,
    output logic       o_grant_ped,
    output logic       o_grant_emerg,
    input  logic       i_grant_ready,
    input  logic       i_phase_done,
    output logic [3:0] o_pending,
    output logic       o_starve_flag,
    output logic       o_busy,
    output logic       o_sched_fault
);

    localparam logic [7:0] AGE_MAX = 8'(MAX_WAIT);

    logic [SYNC_STAGES-1:0][6:0] r_sync;
    logic [6:0]                  w_sync;
    sched_state_e                r_state, w_state_nxt;
    logic [3:0]                  r_pend, w_pend_nxt;
    logic [1:0]                  r_ped, w_ped_nxt;
    logic                        r_emerg, w_emerg_nxt;
    logic [1:0]                  r_emerg_phase, w_emerg_phase_nxt;
    logic [PH_NUM-1:0][7:0]      r_age, w_age_nxt;
    logic [1:0]                  r_rr_ptr, w_rr_ptr_nxt;
    logic [1:0]                  r_grant_phase, w_grant_phase_nxt;
    logic                        r_grant_ped, w_grant_ped_nxt;
    logic                        r_grant_emerg, w_grant_emerg_nxt;
    logic [3:0]                  w_starved;
    logic [1:0]                  w_starve_idx, w_pend_idx, w_sel_phase;
    logic                        w_starve_found, w_pend_found, w_sel_emerg, w_sel_ped;
    logic                        w_accept, w_fault;

    // Bit layout of each sync stage: {emergency, ped[1:0], call[3:0]}.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= {i_emergency_req, i_ped_call, i_call_in};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign w_fault = i_system_fault || (r_state == FAULT);

    always_comb begin
        for (int i = 0; i < PH_NUM; i++) begin
            w_starved[i] = r_pend[i] && (r_age[i] == AGE_MAX);
        end
    end

    phase_rr_picker u_pick_starved (
        .i_mask  (w_starved),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_starve_idx),
        .o_found (w_starve_found)
    );

    phase_rr_picker u_pick_pending (
        .i_mask  (r_pend),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pend_idx),
        .o_found (w_pend_found)
    );

    always_comb begin
        w_sel_emerg = r_emerg;
        if (r_emerg) begin
            w_sel_phase = r_emerg_phase;
        end else if (w_starve_found) begin
            w_sel_phase = w_starve_idx;
        end else begin
            w_sel_phase = w_pend_idx;
        end
        w_sel_ped = !w_sel_phase[0] && r_ped[axis_of(phase_e'(w_sel_phase))];
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_accept          = 1'b0;
        w_grant_phase_nxt = r_grant_phase;
        w_grant_ped_nxt   = r_grant_ped;
        w_grant_emerg_nxt = r_grant_emerg;
        unique case (r_state)
            IDLE: begin
                if (i_system_fault) begin
                    w_state_nxt = FAULT;
                end else if (w_pend_found || r_emerg) begin
                    w_state_nxt       = OFFER;
                    w_grant_phase_nxt = w_sel_phase;
                    w_grant_ped_nxt   = w_sel_ped;
                    w_grant_emerg_nxt = w_sel_emerg;
                end
            end
            OFFER: begin
                if (i_system_fault) begin
                    w_state_nxt = FAULT;
                end else if (i_grant_ready) begin
                    w_state_nxt = SERVICE;
                    w_accept    = 1'b1;
                end
            end
            SERVICE: begin
                if (i_system_fault) begin
                    w_state_nxt = FAULT;
                end else if (i_phase_done) begin
                    w_state_nxt = IDLE;
                end
            end
            FAULT: w_state_nxt = FAULT;
        endcase
    end

    // Acceptance clears win over a same-cycle re-latch; the call re-latches next cycle if held.
    always_comb begin
        w_pend_nxt        = r_pend | w_sync[3:0] | RECALL_MASK;
        w_ped_nxt         = r_ped | w_sync[5:4];
        w_emerg_nxt       = r_emerg;
        w_emerg_phase_nxt = r_emerg_phase;
        w_rr_ptr_nxt      = r_rr_ptr;
        if (w_sync[6]) begin
            w_emerg_nxt       = 1'b1;
            w_emerg_phase_nxt = i_emergency_phase;
        end
        if (w_accept) begin
            w_pend_nxt[r_grant_phase] = 1'b0;
            if (r_grant_ped) begin
                w_ped_nxt[axis_of(phase_e'(r_grant_phase))] = 1'b0;
            end
            if (r_grant_emerg) begin
                w_emerg_nxt = 1'b0;
            end
            w_rr_ptr_nxt = r_grant_phase + 2'd1;
        end
        for (int i = 0; i < PH_NUM; i++) begin
            w_age_nxt[i] = r_age[i];
            if (!r_pend[i] || (w_accept && (r_grant_phase == 2'(i)))) begin
                w_age_nxt[i] = '0;
            end else if (i_tick_1hz && (r_age[i] < AGE_MAX) &&
                         !((r_state == SERVICE) && (r_grant_phase == 2'(i)))) begin
                w_age_nxt[i] = r_age[i] + 8'd1;
            end
        end
        if (w_fault) begin
            w_pend_nxt        = '0;
            w_ped_nxt         = '0;
            w_emerg_nxt       = 1'b0;
            w_emerg_phase_nxt = '0;
            w_age_nxt         = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_pend        <= '0;
            r_ped         <= '0;
            r_emerg       <= 1'b0;
            r_emerg_phase <= '0;
            r_age         <= '0;
            r_rr_ptr      <= '0;
            r_grant_phase <= '0;
            r_grant_ped   <= 1'b0;
            r_grant_emerg <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pend        <= w_pend_nxt;
            r_ped         <= w_ped_nxt;
            r_emerg       <= w_emerg_nxt;
            r_emerg_phase <= w_emerg_phase_nxt;
            r_age         <= w_age_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_grant_phase <= w_grant_phase_nxt;
            r_grant_ped   <= w_grant_ped_nxt;
            r_grant_emerg <= w_grant_emerg_nxt;
        end
    end

    assign o_grant_valid = (r_state == OFFER);
    assign o_grant_phase = o_grant_valid ? r_grant_phase : 2'd0;
    assign o_grant_ped   = o_grant_valid && r_grant_ped;
    assign o_grant_emerg = o_grant_valid && r_grant_emerg;
    assign o_pending     = r_pend;
    assign o_starve_flag = |w_starved;
    assign o_busy        = (r_state == SERVICE);
    assign o_sched_fault = (r_state == FAULT);

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: per-cycle vector tables plus hand-written sequences.
module tb_traffic_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick, em, flt, rdy, done;
    logic [3:0] call;
    logic [1:0] ped, eph;

    logic       gv, gpd, gem, st, bz, sf;
    logic [1:0] gph;
    logic [3:0] pend;

    logic       d_gv, d_gpd, d_gem, d_st, d_bz, d_sf;
    logic [1:0] d_gph;
    logic [3:0] d_pend;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0]  call;
        logic [1:0]  ped;
        logic        em;
        logic [1:0]  eph;
        logic        flt;
        logic        rdy;
        logic        done;
        logic        tick;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    traffic_phase_scheduler #(
        .SYNC_STAGES (2),
        .MAX_WAIT    (3),
        .RECALL_MASK (4'b0000)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_tick_1hz        (tick),
        .i_call_in         (call),
        .i_ped_call        (ped),
        .i_emergency_req   (em),
        .i_emergency_phase (eph),
        .i_system_fault    (flt),
        .o_grant_valid     (gv),
        .o_grant_phase     (gph),
        .o_grant_ped       (gpd),
        .o_grant_emerg     (gem),
        .i_grant_ready     (rdy),
        .i_phase_done      (done),
        .o_pending         (pend),
        .o_starve_flag     (st),
        .o_busy            (bz),
        .o_sched_fault     (sf)
    );

    traffic_phase_scheduler dut_def (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_tick_1hz        (1'b0),
        .i_call_in         (4'b0000),
        .i_ped_call        (2'b00),
        .i_emergency_req   (1'b0),
        .i_emergency_phase (2'b00),
        .i_system_fault    (1'b0),
        .o_grant_valid     (d_gv),
        .o_grant_phase     (d_gph),
        .o_grant_ped       (d_gpd),
        .o_grant_emerg     (d_gem),
        .i_grant_ready     (1'b0),
        .i_phase_done      (1'b0),
        .o_pending         (d_pend),
        .o_starve_flag     (d_st),
        .o_busy            (d_bz),
        .o_sched_fault     (d_sf)
    );

    // Output vector layout: {valid, phase[1:0], ped, emerg, pending[3:0], starve, busy, fault}.
    function automatic logic [11:0] pack(input logic v, input logic [1:0] ph, input logic pd,
                                         input logic e, input logic [3:0] pn, input logic s,
                                         input logic b, input logic f);
        return {v, ph, pd, e, pn, s, b, f};
    endfunction

    function automatic logic [11:0] outs();
        return {gv, gph, gpd, gem, pend, st, bz, sf};
    endfunction

    function automatic logic [11:0] def_outs();
        return {d_gv, d_gph, d_gpd, d_gem, d_pend, d_st, d_bz, d_sf};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic zero_inputs();
        tick = 1'b0; call = '0; ped = '0; em = 1'b0; eph = '0;
        flt = 1'b0; rdy = 1'b0; done = 1'b0;
    endtask

    task automatic reset_dut();
        zero_inputs();
        rst = 1'b1;
        step(2);
        chk("reset_outputs", 32'(outs()), 32'(pack(0, 0, 0, 0, 4'b0000, 0, 0, 0)));
        rst = 1'b0;
    endtask

    task automatic add(input logic [3:0] c, input logic [1:0] p, input logic e,
                       input logic [1:0] ep, input logic f, input logic r, input logic d,
                       input logic t, input logic v, input logic [1:0] ph, input logic pd,
                       input logic ge, input logic [3:0] pn, input logic s, input logic b,
                       input logic ft);
        vec_t x;
        x.call = c; x.ped = p; x.em = e; x.eph = ep;
        x.flt = f; x.rdy = r; x.done = d; x.tick = t;
        x.exp = pack(v, ph, pd, ge, pn, s, b, ft);
        vecs.push_back(x);
    endtask

    task automatic run_table(input string name);
        foreach (vecs[i]) begin
            call = vecs[i].call; ped = vecs[i].ped; em = vecs[i].em; eph = vecs[i].eph;
            flt = vecs[i].flt; rdy = vecs[i].rdy; done = vecs[i].done; tick = vecs[i].tick;
            step();
            chk($sformatf("%s_row%0d", name, i), 32'(outs()), 32'(vecs[i].exp));
        end
        zero_inputs();
        vecs.delete();
    endtask

    task automatic wait_valid(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles && !gv; i++) step();
        chk(name, 32'(gv), 32'd1);
    endtask

    task automatic pulse_call(input logic [3:0] v);
        call = v; step(); call = '0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1; step(); tick = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1; step(); done = 1'b0;
    endtask

    task automatic accept();
        rdy = 1'b1; step(); rdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        zero_inputs();
        reset_dut();
        // Default recall mask latches both straights and offers phase 0.
        step();
        chk("def_recall_pending", 32'(def_outs()), 32'(pack(0, 0, 0, 0, 4'b0101, 0, 0, 0)));
        step();
        chk("def_recall_offer", 32'(def_outs()), 32'(pack(1, 0, 0, 0, 4'b0101, 0, 0, 0)));

        // Single call latency and accept.
        reset_dut();
        //   call     ped  em eph flt rdy dn tk   v  ph  pd em pend     st bz ft
        add(4'b1000, 2'b00, 0, 2'd0, 0, 0, 0, 0,  0, 2'd0, 0, 0, 4'b0000, 0, 0, 0);
        add(4'b1000, 2'b00, 0, 2'd0, 0, 0, 0, 0,  0, 2'd0, 0, 0, 4'b0000, 0, 0, 0);
        add(4'b1000, 2'b00, 0, 2'd0, 0, 0, 0, 0,  0, 2'd0, 0, 0, 4'b1000, 0, 0, 0);
        add(4'b0000, 2'b00, 0, 2'd0, 0, 0, 0, 0,  1, 2'd3, 0, 0, 4'b1000, 0, 0, 0);
        add(4'b0000, 2'b00, 0, 2'd0, 0, 1, 0, 0,  0, 2'd0, 0, 0, 4'b0000, 0, 1, 0);
        add(4'b0000, 2'b00, 0, 2'd0, 0, 0, 1, 0,  0, 2'd0, 0, 0, 4'b0000, 0, 0, 0);
        add(4'b0000, 2'b00, 0, 2'd0, 0, 0, 0, 0,  0, 2'd0, 0, 0, 4'b0000, 0, 0, 0);
        run_table("t1_latency");

        // Round robin over held calls, with stray done in OFFER and ready in IDLE.
        reset_dut();
        add(4'b1111, 2'b00, 0, 2'd0, 0, 0, 0, 0,  0, 2'd0, 0, 0, 4'b0000, 0, 0, 0);
        add(4'b1111, 2'b00, 0, 2'd0, 0, 0, 0, 0,  0, 2'd0, 0, 0, 4'b0000, 0, 0, 0);
        add(4'b1111, 2'b00, 0, 2'd0, 0, 0, 0, 0,  0, 2'd0, 0, 0, 4'b1111, 0, 0, 0);
        add(4'b1111, 2'b00, 0, 2'd0, 0, 0, 0, 0,  1, 2'd0, 0, 0, 4'b1111, 0, 0, 0);
        add(4'b1111, 2'b00, 0, 2'd0, 0, 0, 1, 0,  1, 2'd0, 0, 0, 4'b1111, 0, 0, 0);
        add(4'b1111, 2'b00, 0, 2'd0, 0, 1, 0, 0,  0, 2'd0, 0, 0, 4'b1110, 0, 1, 0);
        add(4'b1111, 2'b00, 0, 2'd0, 0, 0, 1, 0,  0, 2'd0, 0, 0, 4'b1111, 0, 0, 0);
        add(4'b1111, 2'b00, 0, 2'd0, 0, 1, 0, 0,  1, 2'd1, 0, 0, 4'b1111, 0, 0, 0);
        add(4'b1111, 2'b00, 0, 2'd0, 0, 1, 0, 0,  0, 2'd0, 0, 0, 4'b1101, 0, 1, 0);
        add(4'b1111, 2'b00, 0, 2'd0, 0, 0, 1, 0,  0, 2'd0, 0, 0, 4'b1111, 0, 0, 0);
        add(4'b1111, 2'b00, 0, 2'd0, 0, 0, 0, 0,  1, 2'd2, 0, 0, 4'b1111, 0, 0, 0);
        add(4'b1111, 2'b00, 0, 2'd0, 0, 1, 0, 0,  0, 2'd0, 0, 0, 4'b1011, 0, 1, 0);
        add(4'b1111, 2'b00, 0, 2'd0, 0, 0, 1, 0,  0, 2'd0, 0, 0, 4'b1111, 0, 0, 0);
        add(4'b1111, 2'b00, 0, 2'd0, 0, 0, 0, 0,  1, 2'd3, 0, 0, 4'b1111, 0, 0, 0);
        add(4'b1111, 2'b00, 0, 2'd0, 0, 1, 0, 0,  0, 2'd0, 0, 0, 4'b0111, 0, 1, 0);
        add(4'b1111, 2'b00, 0, 2'd0, 0, 0, 1, 0,  0, 2'd0, 0, 0, 4'b1111, 0, 0, 0);
        add(4'b1111, 2'b00, 0, 2'd0, 0, 0, 0, 0,  1, 2'd0, 0, 0, 4'b1111, 0, 0, 0);
        add(4'b1111, 2'b00, 0, 2'd0, 0, 1, 0, 0,  0, 2'd0, 0, 0, 4'b1110, 0, 1, 0);
        add(4'b1111, 2'b00, 0, 2'd0, 0, 0, 1, 0,  0, 2'd0, 0, 0, 4'b1111, 0, 0, 0);
        run_table("t2_round_robin");

        // Emergency raised while phase 1 is in service jumps ahead of pending phase 0.
        reset_dut();
        pulse_call(4'b0010);
        wait_valid("t3_first_offer", 10);
        chk("t3_first_phase", 32'(gph), 32'd1);
        accept();
        chk("t3_in_service", 32'(bz), 32'd1);
        eph = 2'd2;
        pulse_call(4'b0001);
        em = 1'b1; step(); em = 1'b0;
        step(4);
        chk("t3_during_service", 32'(outs()), 32'(pack(0, 0, 0, 0, 4'b0001, 0, 1, 0)));
        pulse_done();
        chk("t3_idle_gap", 32'(gv), 32'd0);
        step();
        chk("t3_emerg_offer", 32'(outs()), 32'(pack(1, 2'd2, 0, 1, 4'b0001, 0, 0, 0)));
        accept();
        chk("t3_emerg_service", 32'(outs()), 32'(pack(0, 0, 0, 0, 4'b0001, 0, 1, 0)));
        pulse_done();
        wait_valid("t3_next_offer", 10);
        chk("t3_next_phase", 32'({gph, gem}), 32'({2'd0, 1'b0}));

        // Starvation: phase 3 ages out during a long service and beats round robin.
        reset_dut();
        pulse_call(4'b0001);
        wait_valid("t4_first_offer", 10);
        accept();
        pulse_call(4'b1000);
        step(2);
        chk("t4_pending3", 32'(pend), 32'h8);
        pulse_tick();
        pulse_tick();
        chk("t4_age2_not_starved", 32'(st), 32'd0);
        pulse_tick();
        chk("t4_age3_starved", 32'(st), 32'd1);
        pulse_tick();
        pulse_tick();
        chk("t4_saturated", 32'(st), 32'd1);
        call = 4'b0011;
        step(3);
        chk("t4_recalled", 32'(pend), 32'hb);
        pulse_done();
        step();
        chk("t4_starved_offer", 32'(outs()), 32'(pack(1, 2'd3, 0, 0, 4'b1011, 1, 0, 0)));
        accept();
        chk("t4_starve_cleared", 32'(st), 32'd0);
        call = '0;

        // Pedestrian walk rides only on the straight of its axis and clears on accept.
        reset_dut();
        ped = 2'b10; step(); ped = 2'b00;
        pulse_call(4'b0100);
        wait_valid("t5_offer_a", 10);
        chk("t5_ped_on_straight", 32'({gph, gpd}), 32'({2'd2, 1'b1}));
        accept();
        pulse_call(4'b0100);
        step(2);
        pulse_done();
        wait_valid("t5_offer_b", 10);
        chk("t5_ped_cleared", 32'({gph, gpd}), 32'({2'd2, 1'b0}));
        accept();
        pulse_done();
        ped = 2'b10; call = 4'b1000; step(); ped = 2'b00; call = '0;
        wait_valid("t5_offer_c", 10);
        chk("t5_left_no_ped", 32'({gph, gpd}), 32'({2'd3, 1'b0}));
        accept();
        pulse_done();
        pulse_call(4'b0100);
        wait_valid("t5_offer_d", 10);
        chk("t5_ped_kept", 32'({gph, gpd}), 32'({2'd2, 1'b1}));

        // Fault beats a same-cycle ready, is sticky, and only reset leaves it.
        reset_dut();
        pulse_call(4'b0001);
        wait_valid("t6_offer", 10);
        flt = 1'b1; rdy = 1'b1; step(); flt = 1'b0; rdy = 1'b0;
        chk("t6_fault_entry", 32'(outs()), 32'(pack(0, 0, 0, 0, 4'b0000, 0, 0, 1)));
        pulse_call(4'b0011);
        step(4);
        chk("t6_fault_sticky", 32'(outs()), 32'(pack(0, 0, 0, 0, 4'b0000, 0, 0, 1)));
        rst = 1'b1; #1;
        chk("t6_async_reset", 32'(outs()), 32'd0);
        step(); rst = 1'b0;

        // Reset in the middle of a handshake returns everything to the reset values.
        pulse_call(4'b0100);
        wait_valid("t6_offer_b", 10);
        rdy = 1'b1; rst = 1'b1; #1;
        chk("t6_mid_handshake_reset", 32'(outs()), 32'd0);
        step(); rst = 1'b0; rdy = 1'b0;
        step(3);
        chk("t6_after_reset_quiet", 32'(outs()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
